ysyx_25040129_mem_arbiter: RTL and testbench

//  Arbitrates two AXI4-Lite style masters onto the single downstream memory/XBAR master port:
//  - IFU: read-only.
//  - LSU: read and write.
//  One transaction is outstanding at a time. The grant is held from the address handshake until
//  the response handshake. Sits between IFU/LSU and the XBAR.
//  A watchdog flags a hung downstream response.

---
 rtl/ysyx_25040129_mem_arbiter_if.sv | 36 +++
 rtl/ysyx_25040129_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_ysyx_25040129_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040129_mem_arbiter_if.sv
// AXI4-Lite style bundle shared by IFU, LSU and the downstream port.
// One definition serves all three sides; the IFU side leaves AW/W/B idle.
interface ysyx_25040129_mem_arbiter_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic [2:0]  arsize;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, arsize, rready,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, arsize, rready,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_25040129_mem_arbiter.sv
// Two-master (IFU read, LSU read/write) arbiter onto one downstream port,
// one outstanding transaction, with a sticky response watchdog.
module ysyx_25040129_mem_arbiter #(
  parameter bit ARB_MODE    = 1'b0,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  ysyx_25040129_mem_arbiter_if.slave  ifu,
  ysyx_25040129_mem_arbiter_if.slave  lsu,
  ysyx_25040129_mem_arbiter_if.master mem,
  output logic bus_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] TM1  = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE, IFU_RD, LSU_RD, LSU_WR
  } state_t;

  state_t        state;
  state_t        nxt;
  logic          last_lsu;
  logic [CW-1:0] wd_cnt;
  logic          ifu_req;
  logic          lsu_req;
  logic          pick_lsu;
  logic          done;

  assign ifu_req  = ifu.arvalid;
  assign lsu_req  = lsu.arvalid | lsu.awvalid;
  // On a tie, mode 0 serves whoever was not granted last.
  assign pick_lsu = lsu_req & (~ifu_req | ARB_MODE | ~last_lsu);

  always_comb begin
    nxt = IDLE;
    if (pick_lsu)
      nxt = lsu.arvalid ? LSU_RD : LSU_WR;
    else if (ifu_req)
      nxt = IFU_RD;
  end

  always_comb begin
    done = 1'b0;
    unique case (state)
      IFU_RD:  done = mem.rvalid & ifu.rready;
      LSU_RD:  done = mem.rvalid & lsu.rready;
      LSU_WR:  done = mem.bvalid & lsu.bready;
      default: done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_lsu    <= 1'b1;
      wd_cnt      <= '0;
      bus_timeout <= 1'b0;
    end else if (state == IDLE) begin
      wd_cnt <= '0;
      state  <= nxt;
      if (nxt != IDLE)
        last_lsu <= (nxt != IFU_RD);
    end else if (done) begin
      state <= IDLE;
    end else begin
      if (wd_cnt != TMAX)
        wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == TM1)
        bus_timeout <= 1'b1;
    end
  end

  always_comb begin
    mem.araddr  = '0;
    mem.arvalid = 1'b0;
    mem.arsize  = '0;
    mem.rready  = 1'b0;
    mem.awaddr  = '0;
    mem.awvalid = 1'b0;
    mem.wdata   = '0;
    mem.wstrb   = '0;
    mem.wvalid  = 1'b0;
    mem.bready  = 1'b0;
    ifu.arready = 1'b0;
    ifu.rdata   = '0;
    ifu.rresp   = '0;
    ifu.rvalid  = 1'b0;
    ifu.awready = 1'b0;
    ifu.wready  = 1'b0;
    ifu.bresp   = '0;
    ifu.bvalid  = 1'b0;
    lsu.arready = 1'b0;
    lsu.rdata   = '0;
    lsu.rresp   = '0;
    lsu.rvalid  = 1'b0;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bresp   = '0;
    lsu.bvalid  = 1'b0;
    unique case (state)
      IFU_RD: begin
        mem.araddr  = ifu.araddr;
        mem.arvalid = ifu.arvalid;
        mem.arsize  = ifu.arsize;
        mem.rready  = ifu.rready;
        ifu.arready = mem.arready;
        ifu.rdata   = mem.rdata;
        ifu.rresp   = mem.rresp;
        ifu.rvalid  = mem.rvalid;
      end
      LSU_RD: begin
        mem.araddr  = lsu.araddr;
        mem.arvalid = lsu.arvalid;
        mem.arsize  = lsu.arsize;
        mem.rready  = lsu.rready;
        lsu.arready = mem.arready;
        lsu.rdata   = mem.rdata;
        lsu.rresp   = mem.rresp;
        lsu.rvalid  = mem.rvalid;
      end
      LSU_WR: begin
        mem.awaddr  = lsu.awaddr;
        mem.awvalid = lsu.awvalid;
        mem.wdata   = lsu.wdata;
        mem.wstrb   = lsu.wstrb;
        mem.wvalid  = lsu.wvalid;
        mem.bready  = lsu.bready;
        lsu.awready = mem.awready;
        lsu.wready  = mem.wready;
        lsu.bresp   = mem.bresp;
        lsu.bvalid  = mem.bvalid;
      end
      default: ;
    endcase
  end

  // IFU is read-only; its write-side inputs are never looked at.
  logic unused_ok;
  assign unused_ok = ^{ifu.awaddr, ifu.awvalid, ifu.wdata,
                       ifu.wstrb, ifu.wvalid, ifu.bready};

endmodule

// File: tb/tb_ysyx_25040129_mem_arbiter.sv
// Directed and randomized bench for the IFU/LSU memory arbiter,
// checked against a transaction-level arbitration model.
module tb_ysyx_25040129_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic to0;
  logic to1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ysyx_25040129_mem_arbiter_if i0 ();
  ysyx_25040129_mem_arbiter_if l0 ();
  ysyx_25040129_mem_arbiter_if m0 ();
  ysyx_25040129_mem_arbiter_if i1 ();
  ysyx_25040129_mem_arbiter_if l1 ();
  ysyx_25040129_mem_arbiter_if m1 ();

  ysyx_25040129_mem_arbiter #(
    .ARB_MODE(1'b0), .TIMEOUT_CYC(8)
  ) dut0 (
    .clk(clk), .rst(rst), .ifu(i0), .lsu(l0),
    .mem(m0), .bus_timeout(to0)
  );

  ysyx_25040129_mem_arbiter #(
    .ARB_MODE(1'b1), .TIMEOUT_CYC(16)
  ) dut1 (
    .clk(clk), .rst(rst), .ifu(i1), .lsu(l1),
    .mem(m1), .bus_timeout(to1)
  );

  // reference model: pending requests and who was served last
  bit          p_ifu, p_lr, p_lw;
  bit          last_lsu_m;
  logic [31:0] a_ifu, a_lr, a_lw, d_lw;
  logic [2:0]  s_ifu, s_lr;
  logic [3:0]  st_lw;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_drives();
    i0.araddr = 0; i0.arvalid = 0; i0.arsize = 0; i0.rready = 1;
    i0.awaddr = 0; i0.awvalid = 0; i0.wdata = 0; i0.wstrb = 0;
    i0.wvalid = 0; i0.bready = 0;
    l0.araddr = 0; l0.arvalid = 0; l0.arsize = 0; l0.rready = 1;
    l0.awaddr = 0; l0.awvalid = 0; l0.wdata = 0; l0.wstrb = 0;
    l0.wvalid = 0; l0.bready = 1;
    m0.arready = 0; m0.rdata = 0; m0.rresp = 0; m0.rvalid = 0;
    m0.awready = 0; m0.wready = 0; m0.bresp = 0; m0.bvalid = 0;
    i1.araddr = 0; i1.arvalid = 0; i1.arsize = 0; i1.rready = 1;
    i1.awaddr = 0; i1.awvalid = 0; i1.wdata = 0; i1.wstrb = 0;
    i1.wvalid = 0; i1.bready = 0;
    l1.araddr = 0; l1.arvalid = 0; l1.arsize = 0; l1.rready = 1;
    l1.awaddr = 0; l1.awvalid = 0; l1.wdata = 0; l1.wstrb = 0;
    l1.wvalid = 0; l1.bready = 1;
    m1.arready = 0; m1.rdata = 0; m1.rresp = 0; m1.rvalid = 0;
    m1.awready = 0; m1.wready = 0; m1.bresp = 0; m1.bvalid = 0;
    p_ifu = 0; p_lr = 0; p_lw = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_drives();
    last_lsu_m = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic req_ifu(input logic [31:0] a, input logic [2:0] s);
    a_ifu = a; s_ifu = s; p_ifu = 1;
    i0.araddr = a; i0.arsize = s; i0.arvalid = 1;
  endtask

  task automatic req_lr(input logic [31:0] a, input logic [2:0] s);
    a_lr = a; s_lr = s; p_lr = 1;
    l0.araddr = a; l0.arsize = s; l0.arvalid = 1;
  endtask

  task automatic req_lw(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] st);
    a_lw = a; d_lw = d; st_lw = st; p_lw = 1;
    l0.awaddr = a; l0.wdata = d; l0.wstrb = st;
    l0.awvalid = 1; l0.wvalid = 1;
  endtask

  // Serve one transaction on dut0 starting from an IDLE cycle.
  task automatic serve(input int ard, input int rdl,
                       input logic [31:0] data, input logic [1:0] resp,
                       input int awd, input int wdl, input int bdl);
    bit          win_lsu;
    logic [31:0] ea;
    logic [2:0]  es;
    int          mx;
    if (!p_ifu) win_lsu = 1;
    else if (!(p_lr || p_lw)) win_lsu = 0;
    else win_lsu = !last_lsu_m;
    last_lsu_m = win_lsu;
    #1 chk("idle_fwd", 32'({m0.arvalid, m0.awvalid}), 0);
    @(negedge clk);
    #1;
    if (!win_lsu || p_lr) begin
      ea = win_lsu ? a_lr : a_ifu;
      es = win_lsu ? s_lr : s_ifu;
      chk("ar_valid", 32'(m0.arvalid), 1);
      chk("ar_addr", m0.araddr, ea);
      chk("ar_size", 32'(m0.arsize), 32'(es));
      chk("wr_off_rd", 32'({m0.awvalid, m0.wvalid, m0.bready}), 0);
      if (win_lsu) begin
        chk("loser_ifu_arready", 32'(i0.arready), 0);
        chk("lsu_aw_off_rd", 32'({l0.awready, l0.wready}), 0);
      end else begin
        chk("loser_lsu_ready",
            32'({l0.arready, l0.awready, l0.wready}), 0);
      end
      repeat (ard) @(negedge clk);
      m0.arready = 1;
      #1 chk("mst_arready", 32'(win_lsu ? l0.arready : i0.arready), 1);
      @(negedge clk);
      m0.arready = 0;
      if (win_lsu) begin l0.arvalid = 0; p_lr = 0; end
      else begin i0.arvalid = 0; p_ifu = 0; end
      repeat (rdl) @(negedge clk);
      m0.rvalid = 1; m0.rdata = data; m0.rresp = resp;
      #1;
      chk("rvalid", 32'(win_lsu ? l0.rvalid : i0.rvalid), 1);
      chk("rdata", win_lsu ? l0.rdata : i0.rdata, data);
      chk("rresp", 32'(win_lsu ? l0.rresp : i0.rresp), 32'(resp));
      chk("loser_rvalid", 32'(win_lsu ? i0.rvalid : l0.rvalid), 0);
    end else begin
      chk("aw_valid", 32'(m0.awvalid), 1);
      chk("aw_addr", m0.awaddr, a_lw);
      chk("w_valid", 32'(m0.wvalid), 1);
      chk("w_data", m0.wdata, d_lw);
      chk("w_strb", 32'(m0.wstrb), 32'(st_lw));
      chk("rd_off_wr", 32'({m0.arvalid, m0.rready}), 0);
      chk("loser_ifu_arready", 32'(i0.arready), 0);
      mx = (awd > wdl) ? awd : wdl;
      for (int c = 0; c <= mx; c++) begin
        m0.awready = (c == awd);
        m0.wready  = (c == wdl);
        #1;
        if (c == awd) chk("mst_awready", 32'(l0.awready), 1);
        if (c == wdl) chk("mst_wready", 32'(l0.wready), 1);
        @(negedge clk);
        if (c == awd) l0.awvalid = 0;
        if (c == wdl) l0.wvalid = 0;
      end
      m0.awready = 0; m0.wready = 0; p_lw = 0;
      repeat (bdl) @(negedge clk);
      m0.bvalid = 1; m0.bresp = resp;
      #1;
      chk("bvalid", 32'(l0.bvalid), 1);
      chk("bresp", 32'(l0.bresp), 32'(resp));
      chk("ifu_arready_wr", 32'(i0.arready), 0);
    end
    @(negedge clk);
    m0.rvalid = 0; m0.bvalid = 0;
    #1 chk("bubble",
           32'({m0.arvalid, m0.awvalid, m0.rready, m0.bready}), 0);
  endtask

  initial begin
    int k;
    rst = 1'b0;
    clear_drives();
    last_lsu_m = 1'b1;
    i0.arvalid = 1; l0.awvalid = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_arvalid", 32'(m0.arvalid), 0);
    chk("rst_awvalid", 32'(m0.awvalid), 0);
    chk("rst_rready", 32'(m0.rready), 0);
    chk("rst_ifu_arready", 32'(i0.arready), 0);
    chk("rst_araddr", m0.araddr, 0);
    chk("rst_timeout", 32'({to0, to1}), 0);
    do_reset();

    req_ifu(32'h3000_0000, 3'd2);
    serve(0, 0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);

    do_reset();
    req_ifu(32'h0000_0100, 3'd2);
    req_lr(32'h0000_0200, 3'd1);
    serve(0, 1, 32'h1111_1111, 2'b00, 0, 0, 0);
    serve(1, 0, 32'h2222_2222, 2'b00, 0, 0, 0);
    req_ifu(32'h0000_0104, 3'd2);
    req_lr(32'h0000_0204, 3'd0);
    serve(0, 0, 32'h3333_3333, 2'b00, 0, 0, 0);
    serve(0, 0, 32'h4444_4444, 2'b00, 0, 0, 0);

    req_ifu(32'h0000_0108, 3'd2);
    serve(0, 0, 32'h5555_5555, 2'b00, 0, 0, 0);
    req_lw(32'h8000_0002, 32'h00AB_0000, 4'b0100);
    req_ifu(32'h0000_010C, 3'd2);
    serve(0, 0, 32'h0, 2'b01, 0, 1, 3);
    serve(0, 0, 32'h6666_6666, 2'b00, 0, 0, 0);

    req_lr(32'h0000_0300, 3'd2);
    serve(0, 0, 32'h7777_7777, 2'b10, 0, 0, 0);
    req_ifu(32'h0000_0110, 3'd2);
    serve(0, 0, 32'h8888_8888, 2'b00, 0, 0, 0);

    repeat (40) begin
      if (!p_ifu && $urandom_range(0, 1) == 1)
        req_ifu($urandom & ~32'h3, 3'($urandom_range(0, 2)));
      if (!p_lr && !p_lw) begin
        k = $urandom_range(0, 3);
        if (k[0]) req_lr($urandom, 3'($urandom_range(0, 2)));
        if (k[1]) req_lw($urandom, $urandom, 4'($urandom_range(1, 15)));
      end
      if (!p_ifu && !p_lr && !p_lw)
        req_ifu($urandom & ~32'h3, 3'd2);
      serve($urandom_range(0, 2), $urandom_range(0, 2), $urandom,
            2'($urandom_range(0, 3)), $urandom_range(0, 2),
            $urandom_range(0, 2), $urandom_range(0, 3));
    end
    chk("no_false_timeout", 32'(to0), 0);

    do_reset();
    req_ifu(32'h0000_4000, 3'd2);
    @(negedge clk);
    repeat (7) @(negedge clk);
    #1 chk("wd_before", 32'(to0), 0);
    @(negedge clk);
    #1 chk("wd_set", 32'(to0), 1);
    repeat (5) @(negedge clk);
    #1;
    chk("wd_sticky", 32'(to0), 1);
    chk("wd_no_abort", 32'(m0.arvalid), 1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_arvalid", 32'(m0.arvalid), 0);
    chk("rst_mid_rready", 32'(m0.rready), 0);
    chk("rst_mid_timeout", 32'(to0), 0);
    i0.arvalid = 0; p_ifu = 0;
    @(negedge clk);
    rst = 1'b1;

    i1.arvalid = 1; i1.araddr = 32'h500; i1.arsize = 3'd2;
    l1.arvalid = 1; l1.araddr = 32'h600; l1.arsize = 3'd2;
    @(negedge clk);
    #1;
    chk("m1_first_lsu", m1.araddr, 32'h600);
    chk("m1_ifu_wait0", 32'(i1.arready), 0);
    m1.arready = 1;
    #1;
    chk("m1_lsu_arready", 32'(l1.arready), 1);
    chk("m1_ifu_wait1", 32'(i1.arready), 0);
    @(negedge clk);
    m1.arready = 0; l1.arvalid = 0;
    m1.rvalid = 1; m1.rdata = 32'h0000_0011;
    #1;
    chk("m1_lsu_rdata", l1.rdata, 32'h0000_0011);
    chk("m1_ifu_rvalid", 32'(i1.rvalid), 0);
    chk("m1_ifu_wait2", 32'(i1.arready), 0);
    @(negedge clk);
    m1.rvalid = 0;
    l1.arvalid = 1; l1.araddr = 32'h604;
    @(negedge clk);
    #1 chk("m1_second_lsu", m1.araddr, 32'h604);
    m1.arready = 1;
    @(negedge clk);
    m1.arready = 0; l1.arvalid = 0; m1.rvalid = 1;
    @(negedge clk);
    m1.rvalid = 0;
    @(negedge clk);
    #1;
    chk("m1_ifu_last", m1.araddr, 32'h500);
    chk("m1_ifu_valid", 32'(m1.arvalid), 1);
    m1.arready = 1;
    @(negedge clk);
    m1.arready = 0; i1.arvalid = 0; m1.rvalid = 1;
    @(negedge clk);
    m1.rvalid = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
